// File: rtl/axi_line_bridge.sv
// axi_line_bridge
//   Merges the cache-side request switch and the AXI master into one block.
//   NUM_RD_CH read requesters (icache/dcache/uncached) are round-robin
//   arbitrated onto a single AXI AR/R channel. One write requester (dcache
//   victim or uncached store) is served on AW/W/B. Each request is either a
//   full-line INCR burst or a single 32-bit word.
//   A read whose line matches an in-flight write is held back until that
//   write has completed.
//
// Ports
//   clk, reset         : clock, asynchronous active-high reset
//   rd_req_i/rd_single_i/rd_addr_i : per-channel read request, mode, address
//   rd_finish_o        : one-cycle pulse per channel when rd_data_o is valid
//   rd_data_o          : returned line (single reads land in word 0)
//   wr_req_i/wr_single_i/wr_addr_i/wr_wstrb_i/wr_data_i : write request
//   wr_rdy_o           : write request accepted on wr_req_i & wr_rdy_o
//   wr_finish_o        : one-cycle pulse after the B handshake
//   ar*/r*/aw*/w*/b*   : AXI master interface
module axi_line_bridge #(
  parameter int NUM_RD_CH  = 2,
  parameter int LINE_WORDS = 8,
  parameter int ID_WIDTH   = 4,
  parameter int WR_ID      = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD_CH-1:0]         rd_req_i,
  input  logic [NUM_RD_CH-1:0]         rd_single_i,
  input  logic [NUM_RD_CH*32-1:0]      rd_addr_i,
  output logic [NUM_RD_CH-1:0]         rd_finish_o,
  output logic [LINE_WORDS*32-1:0]     rd_data_o,
  input  logic                         wr_req_i,
  input  logic                         wr_single_i,
  input  logic [31:0]                  wr_addr_i,
  input  logic [3:0]                   wr_wstrb_i,
  input  logic [LINE_WORDS*32-1:0]     wr_data_i,
  output logic                         wr_rdy_o,
  output logic                         wr_finish_o,
  output logic [ID_WIDTH-1:0]          arid,
  output logic [31:0]                  araddr,
  output logic [7:0]                   arlen,
  output logic [2:0]                   arsize,
  output logic [1:0]                   arburst,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [ID_WIDTH-1:0]          rid,
  input  logic [31:0]                  rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready,
  output logic [ID_WIDTH-1:0]          awid,
  output logic [31:0]                  awaddr,
  output logic [7:0]                   awlen,
  output logic [2:0]                   awsize,
  output logic [1:0]                   awburst,
  output logic                         awvalid,
  input  logic                         awready,
  output logic [31:0]                  wdata,
  output logic [3:0]                   wstrb,
  output logic                         wlast,
  output logic                         wvalid,
  input  logic                         wready,
  input  logic [ID_WIDTH-1:0]          bid,
  input  logic [1:0]                   bresp,
  input  logic                         bvalid,
  output logic                         bready
);

  localparam int LB  = $clog2(LINE_WORDS * 4);
  localparam int CHW = (NUM_RD_CH > 1) ? $clog2(NUM_RD_CH) : 1;
  localparam int WW  = $clog2(LINE_WORDS);
  localparam int BW  = WW + 1;
  localparam logic [7:0] BURST_LEN = 8'(LINE_WORDS - 1);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] R_DONE = 2'd3;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_AW   = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  // read side state
  logic [1:0]                   rstate_q, rstate_d;
  logic [CHW-1:0]               rch_q, rch_d;
  logic [CHW-1:0]               last_q, last_d;
  logic [31:0]                  raddr_q, raddr_d;
  logic                         rsingle_q, rsingle_d;
  logic [BW-1:0]                beat_q, beat_d;
  logic [LINE_WORDS-1:0][31:0]  line_q, line_d;

  // write side state
  logic [1:0]                   wstate_q, wstate_d;
  logic [31:0]                  waddr_q, waddr_d;
  logic [LINE_WORDS-1:0][31:0]  wline_q, wline_d;
  logic [3:0]                   wstrb_q, wstrb_d;
  logic                         wsingle_q, wsingle_d;
  logic [WW-1:0]                wcnt_q, wcnt_d;
  logic                         wfin_q, wfin_d;
  logic                         rdy_en_q, rdy_en_d;

  logic [NUM_RD_CH-1:0]         blocked;
  logic [NUM_RD_CH-1:0]         avail;
  logic                         grant_vld;
  logic [CHW-1:0]               grant_ch;
  int                           rr_idx;
  logic [31:0]                  grant_addr;
  logic [7:0]                   wlen;

  // rid/rresp/bid/bresp carry nothing this master acts on
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, bid, bresp};

  // A read is held while a write to the same line is in flight. The check
  // uses the write address latched at acceptance, so a read granted before
  // the write was accepted is never pulled back.
  always_comb begin
    blocked = '0;
    for (int k = 0; k < NUM_RD_CH; k++) begin
      blocked[k] = (wstate_q != W_IDLE) &&
                   (rd_addr_i[32*k+LB +: 32-LB] == waddr_q[31:LB]);
    end
  end

  assign avail = rd_req_i & ~blocked;

  // Round robin: search starts one past the last channel served. Blocked
  // channels are skipped so an unrelated read is not stuck behind them.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    rr_idx    = 0;
    for (int i = 0; i < NUM_RD_CH; i++) begin
      rr_idx = (int'(last_q) + 1 + i) % NUM_RD_CH;
      if (!grant_vld && avail[rr_idx[CHW-1:0]]) begin
        grant_vld = 1'b1;
        grant_ch  = rr_idx[CHW-1:0];
      end
    end
  end

  assign grant_addr = rd_addr_i[32*grant_ch +: 32];

  always_comb begin
    rstate_d  = rstate_q;
    rch_d     = rch_q;
    last_d    = last_q;
    raddr_d   = raddr_q;
    rsingle_d = rsingle_q;
    beat_d    = beat_q;
    line_d    = line_q;
    case (rstate_q)
      R_IDLE: begin
        if (grant_vld) begin
          rch_d     = grant_ch;
          rsingle_d = rd_single_i[grant_ch];
          raddr_d   = rd_single_i[grant_ch] ? grant_addr
                                            : {grant_addr[31:LB], {LB{1'b0}}};
          beat_d    = '0;
          rstate_d  = R_AR;
        end
      end
      R_AR: begin
        if (arready) rstate_d = R_DATA;
      end
      R_DATA: begin
        if (rvalid) begin
          // beats beyond one line are accepted but dropped
          if (beat_q < BW'(LINE_WORDS)) begin
            line_d[beat_q[WW-1:0]] = rdata;
            beat_d = beat_q + 1'b1;
          end
          if (rlast) rstate_d = R_DONE;
        end
      end
      default: begin
        last_d   = rch_q;
        rstate_d = R_IDLE;
      end
    endcase
  end

  assign wlen = wsingle_q ? 8'd0 : BURST_LEN;

  always_comb begin
    wstate_d  = wstate_q;
    waddr_d   = waddr_q;
    wline_d   = wline_q;
    wstrb_d   = wstrb_q;
    wsingle_d = wsingle_q;
    wcnt_d    = wcnt_q;
    wfin_d    = 1'b0;
    rdy_en_d  = 1'b1;
    case (wstate_q)
      W_IDLE: begin
        if (wr_req_i && rdy_en_q) begin
          waddr_d   = wr_addr_i;
          wline_d   = wr_data_i;
          wstrb_d   = wr_wstrb_i;
          wsingle_d = wr_single_i;
          wcnt_d    = '0;
          wstate_d  = W_AW;
        end
      end
      W_AW: begin
        if (awready) wstate_d = W_DATA;
      end
      W_DATA: begin
        if (wready) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wlast) wstate_d = W_RESP;
        end
      end
      default: begin
        if (bvalid) begin
          wfin_d   = 1'b1;
          wstate_d = W_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstate_q  <= R_IDLE;
      rch_q     <= '0;
      last_q    <= '0;
      raddr_q   <= '0;
      rsingle_q <= 1'b0;
      beat_q    <= '0;
      line_q    <= '0;
      wstate_q  <= W_IDLE;
      waddr_q   <= '0;
      wline_q   <= '0;
      wstrb_q   <= '0;
      wsingle_q <= 1'b0;
      wcnt_q    <= '0;
      wfin_q    <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      rch_q     <= rch_d;
      last_q    <= last_d;
      raddr_q   <= raddr_d;
      rsingle_q <= rsingle_d;
      beat_q    <= beat_d;
      line_q    <= line_d;
      wstate_q  <= wstate_d;
      waddr_q   <= waddr_d;
      wline_q   <= wline_d;
      wstrb_q   <= wstrb_d;
      wsingle_q <= wsingle_d;
      wcnt_q    <= wcnt_d;
      wfin_q    <= wfin_d;
      rdy_en_q  <= rdy_en_d;
    end
  end

  // AXI fields are zeroed outside their own phase so idle outputs are quiet
  assign arvalid = (rstate_q == R_AR);
  assign arid    = arvalid ? ID_WIDTH'(rch_q) : '0;
  assign araddr  = arvalid ? raddr_q : '0;
  assign arlen   = arvalid ? (rsingle_q ? 8'd0 : BURST_LEN) : 8'd0;
  assign arsize  = arvalid ? 3'b010 : 3'b000;
  assign arburst = arvalid ? 2'b01 : 2'b00;
  assign rready  = (rstate_q == R_DATA);

  assign rd_finish_o = (rstate_q == R_DONE) ? (NUM_RD_CH'(1) << rch_q) : '0;
  assign rd_data_o   = line_q;

  assign awvalid = (wstate_q == W_AW);
  assign awid    = awvalid ? ID_WIDTH'(WR_ID) : '0;
  assign awaddr  = !awvalid ? 32'd0 :
                   wsingle_q ? waddr_q : {waddr_q[31:LB], {LB{1'b0}}};
  assign awlen   = awvalid ? wlen : 8'd0;
  assign awsize  = awvalid ? 3'b010 : 3'b000;
  assign awburst = awvalid ? 2'b01 : 2'b00;

  assign wvalid = (wstate_q == W_DATA);
  assign wdata  = wvalid ? wline_q[wcnt_q] : 32'd0;
  assign wstrb  = !wvalid ? 4'h0 : (wsingle_q ? wstrb_q : 4'hF);
  assign wlast  = wvalid && (8'(wcnt_q) == wlen);
  assign bready = (wstate_q == W_RESP);

  assign wr_rdy_o    = rdy_en_q && (wstate_q == W_IDLE);
  assign wr_finish_o = wfin_q;

endmodule

// File: tb/tb_axi_line_bridge.sv
// Directed bench for axi_line_bridge: single and burst reads, round-robin
// alternation, a burst write with throttled wready, read-after-write line
// blocking, and an asynchronous reset in the middle of a read burst.
module tb_axi_line_bridge;
  localparam int NCH = 2;
  localparam int LW  = 8;
  localparam int IDW = 4;

  logic clk = 1'b0;
  logic reset;
  logic [NCH-1:0]     rd_req_i, rd_single_i, rd_finish_o;
  logic [NCH*32-1:0]  rd_addr_i;
  logic [LW*32-1:0]   rd_data_o, wr_data_i;
  logic wr_req_i, wr_single_i, wr_rdy_o, wr_finish_o;
  logic [31:0] wr_addr_i;
  logic [3:0]  wr_wstrb_i;
  logic [IDW-1:0] arid, rid, awid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, rresp, awburst, bresp;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0] wstrb;

  int n_checks = 0;
  int n_fail   = 0;
  logic [LW*32-1:0] exp_line;

  axi_line_bridge #(.NUM_RD_CH(NCH), .LINE_WORDS(LW), .ID_WIDTH(IDW), .WR_ID(1)) dut (
    .clk(clk), .reset(reset),
    .rd_req_i(rd_req_i), .rd_single_i(rd_single_i), .rd_addr_i(rd_addr_i),
    .rd_finish_o(rd_finish_o), .rd_data_o(rd_data_o),
    .wr_req_i(wr_req_i), .wr_single_i(wr_single_i), .wr_addr_i(wr_addr_i),
    .wr_wstrb_i(wr_wstrb_i), .wr_data_i(wr_data_i), .wr_rdy_o(wr_rdy_o),
    .wr_finish_o(wr_finish_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ar(input int budget);
    int n;
    n = 0;
    while (!arvalid && n < budget) begin
      tick();
      n++;
    end
    chk("ar_wait", 256'(arvalid), 256'(1));
  endtask

  // Serve one read: check the AR beat, return nbeats of base+k, check finish.
  task automatic rd_txn(input int ch, input logic [31:0] addr, input logic [7:0] len,
                        input int nbeats, input logic [31:0] base,
                        input logic [NCH-1:0] req_after);
    wait_ar(20);
    chk("arid", 256'(arid), 256'(ch));
    chk("araddr", 256'(araddr), 256'(addr));
    chk("arlen", 256'(arlen), 256'(len));
    chk("arsize_burst", 256'({arsize, arburst}), 256'({3'b010, 2'b01}));
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("rready", 256'(rready), 256'(1));
    for (int k = 0; k < nbeats; k++) begin
      rvalid = 1'b1;
      rdata  = base + 32'(k);
      rlast  = (k == nbeats - 1);
      chk("finish_early", 256'(rd_finish_o), 256'(0));
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    chk("rd_finish", 256'(rd_finish_o), 256'(1 << ch));
    rd_req_i = req_after;
    tick();
    chk("rd_finish_clr", 256'(rd_finish_o), 256'(0));
  endtask

  initial begin
    int n;
    int beats;
    reset = 1'b1;
    rd_req_i = '0; rd_single_i = '0; rd_addr_i = '0;
    wr_req_i = 1'b0; wr_single_i = 1'b0; wr_addr_i = '0; wr_wstrb_i = '0;
    wr_data_i = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
    for (int k = 0; k < LW; k++) wr_data_i[32*k +: 32] = 32'hC000_0000 + 32'(k);

    // ---- reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_rdy", 256'(wr_rdy_o), 256'(0));
    chk("rst_valids", 256'({arvalid, awvalid, wvalid, rready, bready}), 256'(0));
    chk("rst_finish", 256'({rd_finish_o, wr_finish_o}), 256'(0));
    chk("rst_rd_data", rd_data_o, 256'(0));
    chk("rst_ids", 256'({arid, awid, araddr, awaddr, arlen, awlen}), 256'(0));
    reset = 1'b0;
    tick();
    chk("wr_rdy_after_rst", 256'(wr_rdy_o), 256'(1));

    // ---- single read on ch1
    rd_req_i = 2'b10; rd_single_i = 2'b10;
    rd_addr_i[63:32] = 32'hBFAF_8004;
    rd_txn(1, 32'hBFAF_8004, 8'd0, 1, 32'hDEAD_BEEF, 2'b00);
    chk("single_word0", 256'(rd_data_o[31:0]), 256'(32'hDEAD_BEEF));

    // ---- both channels requesting: grants alternate ch0, ch1, ch0
    rd_single_i = 2'b00;
    rd_addr_i[31:0]  = 32'h0000_1104;
    rd_addr_i[63:32] = 32'h0000_1208;
    rd_req_i = 2'b11;
    rd_txn(0, 32'h0000_1100, 8'd7, 8, 32'h10, 2'b11);
    rd_txn(1, 32'h0000_1200, 8'd7, 8, 32'h20, 2'b11);
    rd_txn(0, 32'h0000_1100, 8'd7, 8, 32'h30, 2'b00);
    for (int k = 0; k < LW; k++) exp_line[32*k +: 32] = 32'h30 + 32'(k);
    chk("rr_line", rd_data_o, exp_line);

    // ---- burst read ch0 from mid-line address
    rd_addr_i[31:0] = 32'h1000_0014;
    rd_req_i = 2'b01;
    rd_txn(0, 32'h1000_0000, 8'd7, 8, 32'h0, 2'b00);
    for (int k = 0; k < LW; k++) exp_line[32*k +: 32] = 32'(k);
    chk("burst_line", rd_data_o, exp_line);

    // ---- burst write with wready toggling
    wr_req_i = 1'b1; wr_single_i = 1'b0; wr_addr_i = 32'h0000_2040; wr_wstrb_i = 4'h3;
    tick();
    wr_req_i = 1'b0;
    chk("aw_wr_rdy", 256'(wr_rdy_o), 256'(0));
    chk("awvalid", 256'(awvalid), 256'(1));
    chk("aw_fields", 256'({awid, awaddr, awlen, awsize, awburst}),
        256'({4'd1, 32'h0000_2040, 8'd7, 3'b010, 2'b01}));
    awready = 1'b1;
    tick();
    awready = 1'b0;
    beats = 0;
    for (int c = 0; c < 40 && beats < LW; c++) begin
      wready = c[0];
      if (wvalid && wready) begin
        chk("wdata", 256'(wdata), 256'(32'hC000_0000 + 32'(beats)));
        chk("wstrb_wlast", 256'({wstrb, wlast}), 256'({4'hF, beats == LW - 1}));
        chk("w_wr_rdy", 256'(wr_rdy_o), 256'(0));
        beats++;
      end
      tick();
    end
    wready = 1'b0;
    chk("w_beats", 256'(beats), 256'(LW));
    chk("bready", 256'(bready), 256'(1));
    chk("wr_finish_early", 256'(wr_finish_o), 256'(0));
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("wr_finish", 256'({wr_finish_o, wr_rdy_o}), 256'(2'b11));
    tick();
    chk("wr_finish_clr", 256'(wr_finish_o), 256'(0));

    // ---- pending write to line 0x2040 blocks ch0 read of 0x2048 only
    wr_req_i = 1'b1; wr_addr_i = 32'h0000_2040;
    tick();
    wr_req_i = 1'b0;
    rd_addr_i[31:0]  = 32'h0000_2048;
    rd_addr_i[63:32] = 32'h0000_3000;
    rd_req_i = 2'b11;
    rd_txn(1, 32'h0000_3000, 8'd7, 8, 32'h100, 2'b01);
    repeat (5) tick();
    chk("blocked_ar", 256'(arvalid), 256'(0));
    awready = 1'b1;
    tick();
    awready = 1'b0;
    wready = 1'b1;
    n = 0;
    while (!(wvalid && wlast) && n < 20) begin
      tick();
      n++;
    end
    tick();
    wready = 1'b0;
    chk("blk_bready", 256'({bready, arvalid}), 256'(2'b10));
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("ar_held_b_cycle", 256'({arvalid, wr_finish_o}), 256'(2'b01));
    tick();
    chk("ar_after_b", 256'(arvalid), 256'(1));
    rd_txn(0, 32'h0000_2040, 8'd7, 8, 32'h200, 2'b00);

    // ---- reset during read beat 3
    rd_addr_i[31:0] = 32'h0000_4000;
    rd_req_i = 2'b01;
    wait_ar(20);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rvalid = 1'b1; rdata = 32'hE0 + 32'(k); rlast = 1'b0;
      tick();
    end
    rdata = 32'hE3;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valids", 256'({arvalid, rready, awvalid, wvalid, bready, wr_rdy_o}), 256'(0));
    chk("mid_rst_data", rd_data_o, 256'(0));
    rvalid = 1'b0;
    rd_req_i = 2'b00;
    tick();
    chk("mid_rst_finish", 256'(rd_finish_o), 256'(0));
    reset = 1'b0;
    tick();
    chk("post_rst_rdy", 256'({wr_rdy_o, rd_finish_o}), 256'({1'b1, 2'b00}));
    rd_addr_i[31:0] = 32'h0000_5010;
    rd_req_i = 2'b01;
    rd_txn(0, 32'h0000_5000, 8'd7, 8, 32'h50, 2'b00);
    for (int k = 0; k < LW; k++) exp_line[32*k +: 32] = 32'h50 + 32'(k);
    chk("post_rst_line", rd_data_o, exp_line);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
